// File: rtl/test_unit.sv
// Counts rising edges of an asynchronous level input and the length, in clock
// cycles, of the current (or most recent) high run, after a two-flop synchronizer.
module test_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       f,
   output logic [7:0] z,
   output logic [7:0] x
);

   logic f_p0;
   logic f_p1;
   logic f_p2;
   logic rise;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Stage p0/p1: metastability synchronizer; f_p1 is the synchronized level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_p0 <= 1'b0;
         f_p1 <= 1'b0;
      end else begin
         f_p0 <= f;
         f_p1 <= f_p0;
      end
   end

   // Stage p2: previous synchronized level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_p2 <= 1'b0;
      end else begin
         f_p2 <= f_p1;
      end
   end

   assign rise = f_p1 & ~f_p2;

   // Output stage: x keeps the last run length while the input is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= 8'h00;
         z <= 8'h00;
      end else begin
         if (rise) begin
            x <= 8'h01;
            z <= z + 8'd1;
         end else if (f_p1) begin
            x <= sat_inc(x);
         end
      end
   end

endmodule

// File: tb/tb_test_unit.sv
// Self-checking bench for test_unit: randomized and directed stimulus compared
// against a model derived from the sequence of f values sampled at clock edges.
module tb_test_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       f = 1'b0;
   logic [7:0] x;
   logic [7:0] z;

   int n_checks = 0;
   int n_fail   = 0;

   // Values of f seen at each rising edge since reset release
   bit samp[$];

   test_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .f     (f),
      .z     (z),
      .x     (x)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) samp.delete();
      else        samp.push_back(f);
   end

   // Outputs after edge n reflect the synchronized level, i.e. samples 1..n-2
   function automatic logic [7:0] model_z();
      int n = samp.size() - 2;
      int cnt = 0;
      bit prev = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (samp[i] && !prev) cnt++;
         prev = samp[i];
      end
      return cnt[7:0];
   endfunction

   function automatic logic [7:0] model_x();
      int n = samp.size() - 2;
      int last = -1;
      int len = 0;
      for (int i = n - 1; i >= 0; i--) begin
         if (samp[i]) begin
            last = i;
            break;
         end
      end
      if (last < 0) return 8'h00;
      for (int i = last; i >= 0 && samp[i]; i--) len++;
      if (len > 255) len = 255;
      return len[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         f = 1'($urandom_range(0, 1));
         tick();
         n_checks++;
         if (x !== 8'h00 || z !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: x=%0d z=%0d, required x=0 z=0", x, z);
         end
      end
      f = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (x !== 8'h00 || z !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_after_reset: x=%0d z=%0d, required x=0 z=0", x, z);
         end
      end
   endtask

   task automatic test_single_run();
      f = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_checks++;
         if (x !== model_x() || z !== model_z()) begin
            n_fail++;
            $display("FAIL single_run edge %0d: x=%0d z=%0d, required x=%0d z=%0d",
                     i, x, z, model_x(), model_z());
         end
         if (i == 3) begin
            n_checks++;
            if (x !== 8'd1 || z !== 8'd1) begin
               n_fail++;
               $display("FAIL first_count: x=%0d z=%0d, required x=1 z=1", x, z);
            end
         end
         if (i == 10) begin
            n_checks++;
            if (x !== 8'd8 || z !== 8'd1) begin
               n_fail++;
               $display("FAIL tenth_edge: x=%0d z=%0d, required x=8 z=1", x, z);
            end
         end
      end
      f = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (x !== model_x() || z !== model_z()) begin
            n_fail++;
            $display("FAIL single_run_fall: x=%0d z=%0d, required x=%0d z=%0d",
                     x, z, model_x(), model_z());
         end
      end
   endtask

   task automatic test_saturate();
      do_reset();
      f = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         n_checks++;
         if (x !== model_x() || z !== model_z()) begin
            n_fail++;
            $display("FAIL saturate cycle %0d: x=%0d z=%0d, required x=%0d z=%0d",
                     i, x, z, model_x(), model_z());
         end
      end
      n_checks++;
      if (x !== 8'hFF || z !== 8'd1) begin
         n_fail++;
         $display("FAIL saturate_end: x=%0d z=%0d, required x=255 z=1", x, z);
      end
      f = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (x !== 8'hFF || z !== 8'd1) begin
         n_fail++;
         $display("FAIL saturate_hold: x=%0d z=%0d, required x=255 z=1", x, z);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      f = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      for (int p = 0; p < 257; p++) begin
         f = 1'b1;
         for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (x !== model_x() || z !== model_z()) begin
               n_fail++;
               $display("FAIL wrap_high pulse %0d: x=%0d z=%0d, required x=%0d z=%0d",
                        p, x, z, model_x(), model_z());
            end
         end
         f = 1'b0;
         for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (x !== model_x() || z !== model_z()) begin
               n_fail++;
               $display("FAIL wrap_low pulse %0d: x=%0d z=%0d, required x=%0d z=%0d",
                        p, x, z, model_x(), model_z());
            end
            if (i >= 1) begin
               n_checks++;
               if (x !== 8'd4) begin
                  n_fail++;
                  $display("FAIL low_phase_len pulse %0d: x=%0d, required x=4", p, x);
               end
            end
         end
      end
      tick();
      tick();
      n_checks++;
      if (z !== 8'h01) begin
         n_fail++;
         $display("FAIL wrap_end: z=%0d, required z=1", z);
      end
   endtask

   task automatic test_reset_mid_run();
      f = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (x !== 8'h00 || z !== 8'h00) begin
         n_fail++;
         $display("FAIL async_clear: x=%0d z=%0d, required x=0 z=0", x, z);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++;
         if (x !== model_x() || z !== model_z()) begin
            n_fail++;
            $display("FAIL restart edge %0d: x=%0d z=%0d, required x=%0d z=%0d",
                     i, x, z, model_x(), model_z());
         end
      end
      n_checks++;
      if (x !== 8'd1 || z !== 8'd1) begin
         n_fail++;
         $display("FAIL restart_count: x=%0d z=%0d, required x=1 z=1", x, z);
      end
   endtask

   task automatic test_short_pulse();
      do_reset();
      f = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      f = 1'b1;
      tick();
      f = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (x !== model_x() || z !== model_z()) begin
            n_fail++;
            $display("FAIL short_pulse: x=%0d z=%0d, required x=%0d z=%0d",
                     x, z, model_x(), model_z());
         end
      end
      n_checks++;
      if (x !== 8'd1 || z !== 8'd1) begin
         n_fail++;
         $display("FAIL short_pulse_end: x=%0d z=%0d, required x=1 z=1", x, z);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 60; r++) begin
         int len;
         len = $urandom_range(1, 12);
         f = ~f;
         for (int i = 0; i < len; i++) begin
            // Occasional sub-cycle glitch that no clock edge can see
            if ($urandom_range(0, 7) == 0) begin
               f = ~f;
               #3;
               f = ~f;
            end
            tick();
            n_checks++;
            if (x !== model_x() || z !== model_z()) begin
               n_fail++;
               $display("FAIL random run %0d: x=%0d z=%0d, required x=%0d z=%0d",
                        r, x, z, model_x(), model_z());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_saturate();
      test_wrap();
      test_reset_mid_run();
      test_short_pulse();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
